// File: rtl/alu_mul_sequencer_pkg.sv
// alu_mul_sequencer_pkg: ALU width, opcode set and sequencer states
package alu_mul_sequencer_pkg;
  localparam int WIDTH = 16;
  localparam logic [2:0] OPC_ADD = 3'b000;
  localparam logic [2:0] OPC_SUB = 3'b001;
  localparam logic [2:0] OPC_AND = 3'b010;
  localparam logic [2:0] OPC_OR  = 3'b011;
  localparam logic [2:0] OPC_XOR = 3'b100;
  localparam logic [2:0] OPC_SHL = 3'b101;
  localparam logic [2:0] OPC_SHR = 3'b110;
  localparam logic [2:0] OPC_NOP = 3'b111;
  typedef enum logic [1:0] {IDLE, ADD, DBL, DONE} state_t;
endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-add multiplier that drives an external 16-bit ALU one op per cycle
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_prod,
  output logic             rsp_zer,
  output logic             rsp_neg,
  output logic [WIDTH-1:0] alu_inA,
  output logic [WIDTH-1:0] alu_inB,
  output logic [2:0]       alu_opc,
  output logic             alu_inC,
  input  logic [WIDTH-1:0] alu_outW
);
  state_t state;
  logic [WIDTH-1:0] acc, mcand, mreg;
  logic [3:0] cnt;
  logic busy;
  assign busy    = (state == ADD) || (state == DBL);
  assign alu_opc = busy ? OPC_ADD : OPC_NOP;
  assign alu_inA = (state == ADD) ? acc : (state == DBL) ? mcand : '0;
  assign alu_inB = busy ? mcand : '0;
  assign alu_inC = 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mreg      <= '0;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_prod  <= '0;
      rsp_zer   <= 1'b1;
      rsp_neg   <= 1'b0;
    end else
      case (state)
        IDLE:
          if (req_valid) begin
            acc       <= '0;
            mcand     <= req_a;
            mreg      <= req_b;
            cnt       <= '0;
            req_ready <= 1'b0;
            if (req_b == '0) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_prod  <= '0;
              rsp_zer   <= 1'b1;
              rsp_neg   <= 1'b0;
            end else
              state <= req_b[0] ? ADD : DBL;
          end
        ADD: begin
          acc   <= alu_outW;
          state <= DBL;
        end
        DBL: begin
          mcand <= alu_outW;
          mreg  <= mreg >> 1;
          cnt   <= cnt + 4'd1;
          // acc is final here: DBL never touches it, so the response latches it directly
          if (mreg[WIDTH-1:1] == '0 || cnt == 4'd15) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_prod  <= acc;
            rsp_zer   <= acc == '0;
            rsp_neg   <= acc[WIDTH-1];
          end else
            state <= mreg[1] ? ADD : DBL;
        end
        DONE:
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
      endcase
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed multiply vectors against a behavioural ALU
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_zer, rsp_neg, alu_inC;
  logic [15:0] req_a = 0, req_b = 0, rsp_prod, alu_inA, alu_inB, alu_outW;
  logic [2:0] alu_opc;
  logic [31:0] pat;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  assign alu_outW = (alu_opc == OPC_ADD) ? alu_inA + alu_inB + {15'b0, alu_inC} : '0;
  alu_mul_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_prod(rsp_prod), .rsp_zer(rsp_zer), .rsp_neg(rsp_neg),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_opc(alu_opc), .alu_inC(alu_inC),
    .alu_outW(alu_outW)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic check_reset_state();
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_prod", rsp_prod, 0);
    check("rst_rsp_zer", rsp_zer, 1);
    check("rst_rsp_neg", rsp_neg, 0);
    check("rst_alu_opc", alu_opc, OPC_NOP);
    check("rst_alu_ops", {alu_inA, alu_inB}, 0);
  endtask
  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] prod,
                     input int n_exp, input int hold, output logic [31:0] p);
    int n = 0, bad_opc = 0, bad_hold = 0;
    p = 0;
    @(negedge clk);
    check("idle_ready", req_ready, 1);
    check("idle_opc", alu_opc, OPC_NOP);
    req_valid = 1; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 0;
    check("busy_ready", req_ready, 0);
    while (!rsp_valid && n < 40) begin
      p = {p[30:0], alu_inA == alu_inB};
      if (alu_opc !== OPC_ADD || alu_inC !== 1'b0) bad_opc++;
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, n_exp);
    check("op_opc", bad_opc, 0);
    check("rsp_prod", rsp_prod, prod);
    check("rsp_zer", rsp_zer, prod == 0);
    check("rsp_neg", rsp_neg, prod[15]);
    check("done_opc", {alu_opc, alu_inA, alu_inB}, {OPC_NOP, 32'h0});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_valid = h[0]; req_a = 16'h0055; req_b = 16'h0003;
      if (rsp_valid !== 1 || rsp_prod !== prod || req_ready !== 0) bad_hold++;
    end
    if (hold > 0) check("hold_stable", bad_hold, 0);
    @(negedge clk);
    req_valid = 0; rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    check("post_valid", rsp_valid, 0);
    check("post_ready", req_ready, 1);
  endtask
  initial begin
    #2 rst = 1;
    #2 check_reset_state();
    @(negedge clk) rst = 0;
    run(16'd3, 16'd5, 16'd15, 5, 0, pat);
    check("seq_3x5", pat[4:0], 5'b01101);
    run(16'h1234, 16'h0000, 16'h0000, 0, 0, pat);
    run(16'hFFFF, 16'hFFFF, 16'h0001, 32, 0, pat);
    run(16'h0100, 16'h0100, 16'h0000, 10, 0, pat);
    run(16'h8000, 16'h0001, 16'h8000, 2, 0, pat);
    run(16'd3, 16'd5, 16'd15, 5, 10, pat);
    @(negedge clk);
    req_valid = 1; req_a = 16'd7; req_b = 16'hF0F0;
    @(posedge clk); #1;
    req_valid = 0;
    check("mid_in_dbl", {alu_opc, 1'b0, alu_inA == alu_inB}, {OPC_ADD, 2'b01});
    rst = 1;
    #1 check_reset_state();
    @(negedge clk) rst = 0;
    run(16'd2, 16'd3, 16'd6, 4, 0, pat);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
